// File: rtl/id_ex_stage_if.sv
// Bus between decode and the ID/EX stage: decoded instruction and producer
// write-back info flow in; ALU operands, EX controls and stall flow out.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_alu_sel;
    logic [2:0]      id_func3;
    logic            id_src1_pc;
    logic            id_src2_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;
    logic            id_jump;
    logic            flush;
    logic            exmem_reg_write;
    logic            memwb_reg_write;
    logic [RA_W-1:0] exmem_rd;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] exmem_result;
    logic [XLEN-1:0] memwb_result;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [3:0]      alu_sel;
    logic [2:0]      alu_func3;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_jump;
    logic            stall;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_sel, id_func3, id_src1_pc, id_src2_imm, id_reg_write, id_mem_read,
               id_mem_write, id_branch, id_jump, flush, exmem_reg_write, memwb_reg_write,
               exmem_rd, memwb_rd, exmem_result, memwb_result,
        input  alu_in1, alu_in2, alu_sel, alu_func3, ex_valid, ex_pc, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_sel, id_func3, id_src1_pc, id_src2_imm, id_reg_write, id_mem_read,
               id_mem_write, id_branch, id_jump, flush, exmem_reg_write, memwb_reg_write,
               exmem_rd, memwb_rd, exmem_result, memwb_result,
        output alu_in1, alu_in2, alu_sel, alu_func3, ex_valid, ex_pc, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand hazard handling and flush/stall bubbles.
// Macro ID_EX_FORWARDING_EN enables EX/MEM and MEM/WB forwarding; without it the
// stage stalls until no in-flight producer writes an ID source register.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam int unsigned CW = 5;  // {reg_write, mem_read, mem_write, branch, jump}

    logic            valid_q, valid_d;
    logic [CW-1:0]   ctrl_q, ctrl_d;
    logic [3:0]      alu_sel_q, alu_sel_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
    logic            src1_pc_q, src2_imm_q;
    logic            stall;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    function automatic logic producer_hit(input logic [RA_W-1:0] src, input logic wr,
                                          input logic [RA_W-1:0] rd);
        return wr && (rd != '0) && (rd == src);
    endfunction

    always_comb begin
        valid_d   = bus.id_valid;
        ctrl_d    = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump};
        alu_sel_d = bus.id_alu_sel;
        func3_d   = bus.id_func3;
        if (bus.flush || stall || !bus.id_valid) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            alu_sel_d = '0;
            func3_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            alu_sel_q  <= '0;
            func3_q    <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            src1_pc_q  <= 1'b0;
            src2_imm_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            alu_sel_q  <= alu_sel_d;
            func3_q    <= func3_d;
            pc_q       <= bus.id_pc;
            rs1_data_q <= bus.id_rs1_data;
            rs2_data_q <= bus.id_rs2_data;
            imm_q      <= bus.id_imm;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            src1_pc_q  <= bus.id_src1_pc;
            src2_imm_q <= bus.id_src2_imm;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // EX/MEM is younger than MEM/WB, so it wins when both write the same rd.
    always_comb begin
        if (producer_hit(rs1_q, bus.exmem_reg_write, bus.exmem_rd)) begin
            fwd_rs1 = bus.exmem_result;
        end else if (producer_hit(rs1_q, bus.memwb_reg_write, bus.memwb_rd)) begin
            fwd_rs1 = bus.memwb_result;
        end else begin
            fwd_rs1 = rs1_data_q;
        end
        if (producer_hit(rs2_q, bus.exmem_reg_write, bus.exmem_rd)) begin
            fwd_rs2 = bus.exmem_result;
        end else if (producer_hit(rs2_q, bus.memwb_reg_write, bus.memwb_rd)) begin
            fwd_rs2 = bus.memwb_result;
        end else begin
            fwd_rs2 = rs2_data_q;
        end
    end

    assign stall = bus.id_valid & valid_q & ctrl_q[3] & (rd_q != '0)
                 & ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
`else
    logic unused_fwd;
    logic rs1_busy, rs2_busy;

    assign unused_fwd = ^{bus.exmem_result, bus.memwb_result, rs1_q, rs2_q};
    assign fwd_rs1    = rs1_data_q;
    assign fwd_rs2    = rs2_data_q;

    always_comb begin
        rs1_busy = producer_hit(bus.id_rs1, valid_q & ctrl_q[4], rd_q)
                 | producer_hit(bus.id_rs1, bus.exmem_reg_write, bus.exmem_rd)
                 | producer_hit(bus.id_rs1, bus.memwb_reg_write, bus.memwb_rd);
        rs2_busy = producer_hit(bus.id_rs2, valid_q & ctrl_q[4], rd_q)
                 | producer_hit(bus.id_rs2, bus.exmem_reg_write, bus.exmem_rd)
                 | producer_hit(bus.id_rs2, bus.memwb_reg_write, bus.memwb_rd);
    end

    assign stall = bus.id_valid & (rs1_busy | rs2_busy);
`endif

    assign bus.alu_in1       = src1_pc_q ? pc_q : fwd_rs1;
    assign bus.alu_in2       = src2_imm_q ? imm_q : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.alu_sel       = alu_sel_q;
    assign bus.alu_func3     = func3_q;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_rd         = rd_q;
    assign {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_jump}
                             = ctrl_q & {CW{valid_q}};
    assign bus.stall         = stall;
endmodule
